apb_usrt_master: RTL and testbench
==================================

# apb_usrt_master

APB initiator that drives single-beat read/write transactions into the USRT peripheral's APB slave port (`pSelect`, `pEnable`, `pWrite`, `pAddress`, `pWData` → `pReady`, `pRData`, `pSlvErr`). Upstream logic (test sequencer or CPU-side glue) issues one command through a valid/ready interface and receives one response through a valid/ready interface. The block owns the APB SETUP/ACCESS sequencing, and optionally a watchdog that aborts hung transfers.

## Interface
Parameters:
- `ADDR_W`, 32: APB address width.
- `TIMEOUT_CYCLES`, 255: ACCESS-phase cycles without `pReady` before abort. Used only with the watchdog macro; legal range ≥ 1.

Ports:
- `pClk` in 1: APB clock; the only clock.
- `pReset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in `ADDR_W`: target address.
- `cmd_wdata` in 8: write data.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out 8: read data; 0 for writes.
- `rsp_err` out 1: slave error or timeout.
- `pSelect` out 1: APB PSEL.
- `pEnable` out 1: APB PENABLE.
- `pWrite` out 1: APB PWRITE.
- `pAddress` out `ADDR_W`: APB PADDR.
- `pWData` out 8: APB PWDATA.
- `pRData` in 8: APB PRDATA.
- `pReady` in 1: APB PREADY.
- `pSlvErr` in 1: APB PSLVERR; tie to 0 if the slave has none.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: `cmd_ready` = 1. On handshake, register `cmd_write`, `cmd_addr`, and `cmd_wdata` (`pWData` = 0 for reads), then go to SETUP.
- SETUP: `pSelect` = 1, `pEnable` = 0, `cmd_ready` = 0. Always exactly one cycle, then ACCESS.
- ACCESS: `pSelect` = 1, `pEnable` = 1. `pAddress`, `pWrite`, and `pWData` stay stable from SETUP through the end of ACCESS.
- ACCESS completion: on a cycle with `pReady` = 1, capture `pRData` (reads only) and `pSlvErr` into `rsp_rdata` and `rsp_err`, then go to RESP.
- RESP: `pSelect` = `pEnable` = 0, `rsp_valid` = 1. `rsp_*` is held until `rsp_ready` = 1, then go to IDLE.
- One outstanding transaction at a time. No command is accepted during SETUP, ACCESS, or RESP.
- All outputs are registered; no combinational path from any input to any output.

## Timing
- Reset values: every output is 0 except `cmd_ready`, which is 1. FSM state is IDLE.
- Reset mid-transaction: on the next edge `pSelect`/`pEnable` drop to 0. The transaction is discarded and no response is issued.
- Minimum latency (`pReady` = 1 on the first ACCESS cycle, `rsp_ready` held high):
  - handshake at edge 0;
  - SETUP during cycle 1;
  - ACCESS during cycle 2;
  - `rsp_valid` during cycle 3;
  - IDLE / `cmd_ready` = 1 during cycle 4.
- Each `pReady` wait cycle adds one cycle. Each `rsp_ready` stall adds one cycle.
- `pReady` is ignored outside ACCESS.

## Configuration
- Macro `APB_USRT_MASTER_TIMEOUT_EN`.
- Defined:
  - A counter clears on entering ACCESS and increments on every ACCESS cycle with `pReady` = 0.
  - When the counter reaches `TIMEOUT_CYCLES` and `pReady` is still 0, the transfer aborts: go to RESP with `rsp_err` = 1 and `rsp_rdata` = 0, and deassert `pSelect`/`pEnable`.
  - If `pReady` rises in the same cycle the limit is reached, `pReady` wins and the transfer completes normally.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- Undefined: no counter; ACCESS waits indefinitely and `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `apb_usrt_pkg` holds:
  - the FSM state enum (IDLE/SETUP/ACCESS/RESP);
  - default `ADDR_W`;
  - default `TIMEOUT_CYCLES`.
- One sub-module, `apb_watchdog`: counter plus expiry flag, with clear/enable/expired ports. It is instantiated only under `APB_USRT_MASTER_TIMEOUT_EN`.

## Test plan
- Write, zero wait: addr 0x4, wdata 0xA5, `pReady` = 1 → SETUP one cycle, ACCESS one cycle with `pWrite` = 1 and `pWData` = 0xA5, then `rsp_valid` with `rsp_err` = 0, `rsp_rdata` = 0x00.
- Read, 3 wait states: `pRData` = 0x3C when `pReady` rises → `rsp_rdata` = 0x3C, `rsp_valid` 6 cycles after the handshake, address stable throughout.
- Slave error: write with `pSlvErr` = 1 alongside `pReady` → `rsp_err` = 1. Then hold `rsp_ready` = 0 for 4 cycles → `rsp_*` stable and `cmd_ready` = 0 until the consume cycle.
- Reset asserted during ACCESS → next cycle `pSelect` = `pEnable` = 0, `rsp_valid` = 0, `cmd_ready` = 1 after reset release; a following read completes normally.
- Timeout (macro on, `TIMEOUT_CYCLES` = 4, `pReady` held 0) → abort after 4 ACCESS cycles with `rsp_err` = 1. Separately, `pReady` rising on the 4th cycle → normal completion with `rsp_err` = 0.
- Back-to-back: `cmd_valid` held high for two commands → second accepted only in IDLE after the first response is consumed; no overlap of `pSelect`.

Source files
------------

// File: rtl/apb_usrt_pkg.sv
// Shared types and defaults for the APB initiator that drives the USRT slave port.
// FSM state encoding plus default address width and watchdog limit.
package apb_usrt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int APB_ADDR_W_DEF  = 32;
    localparam int APB_TIMEOUT_DEF = 255;

endpackage : apb_usrt_pkg

// File: rtl/apb_watchdog.sv
// ACCESS-phase watchdog: counts stalled cycles and flags the cycle on which the
// limit is reached. Only instantiated when APB_USRT_MASTER_TIMEOUT_EN is defined.
module apb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Expiry fires on the stalled cycle that would bring the count up to the limit.
    assign expired_o = enable_i && (cnt_q == LAST_CNT);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && !expired_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule : apb_watchdog

// File: rtl/apb_usrt_master.sv
// Single-outstanding APB initiator with valid/ready command and response ports.
// Optional ACCESS watchdog enabled by defining APB_USRT_MASTER_TIMEOUT_EN.
module apb_usrt_master
    import apb_usrt_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W_DEF,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEF
) (
    input  logic              pClk,
    input  logic              pReset,
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid and its payload must hold until then, ready may change freely.
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    output logic              pSelect,
    output logic              pEnable,
    output logic              pWrite,
    output logic [ADDR_W-1:0] pAddress,
    output logic [7:0]        pWData,
    input  logic [7:0]        pRData,
    input  logic              pReady,
    input  logic              pSlvErr,
    output apb_state_e        dbg_state
);

    apb_state_e        state_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [7:0]        rsp_rdata_q;
    logic              rsp_err_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [7:0]        pwdata_q;
    logic              wd_expired;

`ifdef APB_USRT_MASTER_TIMEOUT_EN
    apb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (pClk),
        .rst_i     (pReset),
        .clear_i   (state_q == SETUP),
        .enable_i  ((state_q == ACCESS) && !pReady),
        .expired_o (wd_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign wd_expired     = 1'b0;
`endif

    always_ff @(posedge pClk) begin
        if (pReset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        psel_q      <= 1'b1;
                        pwrite_q    <= cmd_write;
                        paddr_q     <= cmd_addr;
                        pwdata_q    <= cmd_write ? cmd_wdata : 8'h00;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // A completing pReady outranks a watchdog expiry on the same cycle.
                    if (pReady) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwrite_q ? 8'h00 : pRData;
                        rsp_err_q   <= pSlvErr;
                        state_q     <= RESP;
                    end else if (wd_expired) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= 8'h00;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 8'h00;
                        rsp_err_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign pSelect   = psel_q;
    assign pEnable   = penable_q;
    assign pWrite    = pwrite_q;
    assign pAddress  = paddr_q;
    assign pWData    = pwdata_q;
    assign dbg_state = state_q;

endmodule : apb_usrt_master

// File: tb/tb_apb_usrt_master.sv
// Directed self-checking bench for apb_usrt_master; the timeout scenario follows
// whether APB_USRT_MASTER_TIMEOUT_EN is defined for the build.
module tb_apb_usrt_master;
    import apb_usrt_pkg::*;

    localparam int ADDR_W = 32;

    logic              pClk;
    logic              pReset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_rdata;
    logic              rsp_err;
    logic              pSelect;
    logic              pEnable;
    logic              pWrite;
    logic [ADDR_W-1:0] pAddress;
    logic [7:0]        pWData;
    logic [7:0]        pRData;
    logic              pReady;
    logic              pSlvErr;
    apb_state_e        dbg_state;

    int checks;
    int failures;

    apb_usrt_master #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pClk      (pClk),
        .pReset    (pReset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .pSelect   (pSelect),
        .pEnable   (pEnable),
        .pWrite    (pWrite),
        .pAddress  (pAddress),
        .pWData    (pWData),
        .pRData    (pRData),
        .pReady    (pReady),
        .pSlvErr   (pSlvErr),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    // Advance one clock; outputs are settled at return, inputs set next are
    // sampled on the following rising edge.
    task automatic step();
        @(posedge pClk);
        #1;
    endtask

    // Driver: issue one command and play the slave with `waits` stalled ACCESS
    // cycles. Returns in the first cycle with rsp_valid high (rsp_ready kept low).
    // lat counts cycles from the handshake edge, -1 if no response arrived.
    task automatic drive_txn(input logic wr, input logic [ADDR_W-1:0] addr,
                             input logic [7:0] wd, input logic [7:0] rd,
                             input logic serr, input int waits,
                             output int lat, output logic stable_ok);
        int acc;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        pReady    = 1'b0;
        pRData    = 8'hEE;
        pSlvErr   = 1'b0;
        rsp_ready = 1'b0;
        step();
        cmd_valid = 1'b0;
        cmd_addr  = ~addr;
        cmd_wdata = ~wd;
        cmd_write = ~wr;
        lat       = 1;
        acc       = 0;
        stable_ok = 1'b1;
        while (!rsp_valid && lat < 300) begin
            if (!pSelect || pAddress !== addr || pWrite !== wr
                || pWData !== (wr ? wd : 8'h00) || cmd_ready !== 1'b0)
                stable_ok = 1'b0;
            if (lat == 1 && pEnable) stable_ok = 1'b0;
            if (pEnable) acc++;
            if (pEnable && acc > waits) begin
                pReady  = 1'b1;
                pRData  = rd;
                pSlvErr = serr;
            end else begin
                pReady  = 1'b0;
                pRData  = 8'hEE;
                pSlvErr = 1'b0;
            end
            step();
            lat++;
        end
        pReady  = 1'b0;
        pRData  = 8'hEE;
        pSlvErr = 1'b0;
        if (!rsp_valid) lat = -1;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        pReset = 1'b1;
        repeat (3) step();
        pReset = 1'b0;
        step();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
        end
        checks++;
        if ({rsp_valid, rsp_err, pSelect, pEnable, pWrite} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {rsp_valid, rsp_err, pSelect, pEnable, pWrite});
        end
        checks++;
        if (pAddress !== '0 || pWData !== 8'h00 || rsp_rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: got addr=%0h wdata=%0h rdata=%0h expected 0 0 0",
                     pAddress, pWData, rsp_rdata);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
        end
    endtask

    task automatic test_write_zero_wait();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h4;
        cmd_wdata = 8'hA5;
        rsp_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        checks++;
        if ({pSelect, pEnable, cmd_ready} !== 3'b100) begin
            failures++;
            $display("FAIL wr_setup: got sel/en/rdy=%b expected 100", {pSelect, pEnable, cmd_ready});
        end
        step();
        pReady = 1'b1;
        checks++;
        if ({pSelect, pEnable, pWrite} !== 3'b111 || pWData !== 8'hA5 || pAddress !== 32'h4) begin
            failures++;
            $display("FAIL wr_access: got sel/en/wr=%b wdata=%0h addr=%0h expected 111 a5 4",
                     {pSelect, pEnable, pWrite}, pWData, pAddress);
        end
        step();
        pReady = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00
            || pSelect !== 1'b0 || pEnable !== 1'b0) begin
            failures++;
            $display("FAIL wr_resp: got valid=%b err=%b rdata=%0h sel=%b en=%b expected 1 0 0 0 0",
                     rsp_valid, rsp_err, rsp_rdata, pSelect, pEnable);
        end
        step();
        rsp_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_idle: got rdy=%b valid=%b expected 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_read_waits();
        int   lat;
        logic ok;
        drive_txn(1'b0, 32'h10, 8'h55, 8'h3C, 1'b0, 3, lat, ok);
        checks++;
        if (lat != 6) begin
            failures++;
            $display("FAIL rd_latency: got %0d expected 6", lat);
        end
        checks++;
        if (rsp_rdata !== 8'h3C || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL rd_data: got rdata=%0h err=%b expected 3c 0", rsp_rdata, rsp_err);
        end
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL rd_stable: got %b expected 1", ok);
        end
        consume();
    endtask

    task automatic test_slave_error();
        int   lat;
        logic ok;
        drive_txn(1'b1, 32'h8, 8'h5A, 8'hC3, 1'b1, 0, lat, ok);
        checks++;
        if (lat != 3 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00) begin
            failures++;
            $display("FAIL err_resp: got lat=%0d err=%b rdata=%0h expected 3 1 0", lat, rsp_err, rsp_rdata);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00 || cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL err_hold%0d: got valid=%b err=%b rdata=%0h rdy=%b expected 1 1 0 0",
                         i, rsp_valid, rsp_err, rsp_rdata, cmd_ready);
            end
        end
        consume();
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_consume: got rdy=%b valid=%b expected 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_access();
        int   lat;
        logic ok;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h18;
        cmd_wdata = 8'h42;
        pReady    = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        checks++;
        if (pEnable !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_access: got en=%b expected 1", pEnable);
        end
        pReset = 1'b1;
        step();
        checks++;
        if ({pSelect, pEnable, rsp_valid} !== 3'b000) begin
            failures++;
            $display("FAIL rst_drop: got sel/en/valid=%b expected 000", {pSelect, pEnable, rsp_valid});
        end
        pReset = 1'b0;
        step();
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_release: got rdy=%b valid=%b expected 1 0", cmd_ready, rsp_valid);
        end
        drive_txn(1'b0, 32'h20, 8'h00, 8'h77, 1'b0, 0, lat, ok);
        checks++;
        if (lat != 3 || rsp_rdata !== 8'h77 || rsp_err !== 1'b0 || ok !== 1'b1) begin
            failures++;
            $display("FAIL rst_followup: got lat=%0d rdata=%0h err=%b ok=%b expected 3 77 0 1",
                     lat, rsp_rdata, rsp_err, ok);
        end
        consume();
    endtask

    task automatic test_timeout();
        int   lat;
        logic ok;
`ifdef APB_USRT_MASTER_TIMEOUT_EN
        drive_txn(1'b0, 32'h24, 8'h00, 8'h66, 1'b0, 100, lat, ok);
        checks++;
        if (lat != 6 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00 || pSelect !== 1'b0 || pEnable !== 1'b0) begin
            failures++;
            $display("FAIL to_abort: got lat=%0d err=%b rdata=%0h sel=%b en=%b expected 6 1 0 0 0",
                     lat, rsp_err, rsp_rdata, pSelect, pEnable);
        end
        consume();
        drive_txn(1'b0, 32'h28, 8'h00, 8'h66, 1'b0, 3, lat, ok);
        checks++;
        if (lat != 6 || rsp_err !== 1'b0 || rsp_rdata !== 8'h66) begin
            failures++;
            $display("FAIL to_ready_wins: got lat=%0d err=%b rdata=%0h expected 6 0 66", lat, rsp_err, rsp_rdata);
        end
        consume();
`else
        drive_txn(1'b0, 32'h24, 8'h00, 8'h66, 1'b0, 10, lat, ok);
        checks++;
        if (lat != 13 || rsp_err !== 1'b0 || rsp_rdata !== 8'h66 || ok !== 1'b1) begin
            failures++;
            $display("FAIL no_timeout_wait: got lat=%0d err=%b rdata=%0h ok=%b expected 13 0 66 1",
                     lat, rsp_err, rsp_rdata, ok);
        end
        consume();
`endif
    endtask

    task automatic test_back_to_back();
        int         nacc;
        int         nrsp;
        int         acc_t[2];
        int         sel_rises;
        int         overlap;
        logic [7:0] rd[2];
        logic       acc_now;
        logic       sel_prev;
        nacc      = 0;
        nrsp      = 0;
        sel_rises = 0;
        overlap   = 0;
        sel_prev  = 1'b0;
        acc_t[0]  = -1;
        acc_t[1]  = -1;
        rd[0]     = 8'hFF;
        rd[1]     = 8'hFF;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h30;
        cmd_wdata = 8'h11;
        pReady    = 1'b1;
        pRData    = 8'h99;
        rsp_ready = 1'b1;
        for (int t = 0; t < 14; t++) begin
            acc_now = cmd_valid && cmd_ready;
            if (acc_now && (pSelect || rsp_valid)) overlap++;
            if (pSelect && (cmd_ready || rsp_valid)) overlap++;
            if (pSelect && !sel_prev) sel_rises++;
            sel_prev = pSelect;
            if (rsp_valid) begin
                if (nrsp < 2) rd[nrsp] = rsp_rdata;
                nrsp++;
            end
            if (acc_now) begin
                if (nacc < 2) acc_t[nacc] = t;
                nacc++;
            end
            step();
            if (acc_now && nacc == 1) begin
                cmd_write = 1'b0;
                cmd_addr  = 32'h34;
            end
            if (acc_now && nacc == 2) cmd_valid = 1'b0;
        end
        pReady    = 1'b0;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        checks++;
        if (nacc != 2 || acc_t[1] - acc_t[0] != 4) begin
            failures++;
            $display("FAIL b2b_accept: got n=%0d gap=%0d expected 2 4", nacc, acc_t[1] - acc_t[0]);
        end
        checks++;
        if (nrsp != 2 || rd[0] !== 8'h00 || rd[1] !== 8'h99) begin
            failures++;
            $display("FAIL b2b_resp: got n=%0d rd0=%0h rd1=%0h expected 2 0 99", nrsp, rd[0], rd[1]);
        end
        checks++;
        if (overlap != 0 || sel_rises != 2) begin
            failures++;
            $display("FAIL b2b_overlap: got overlap=%0d sel_rises=%0d expected 0 2", overlap, sel_rises);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        pReset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = 8'h00;
        rsp_ready = 1'b0;
        pRData    = 8'h00;
        pReady    = 1'b0;
        pSlvErr   = 1'b0;
        test_reset();
        test_write_zero_wait();
        test_read_waits();
        test_slave_error();
        test_reset_mid_access();
        test_timeout();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_apb_usrt_master
